lfsr_delay_gen: RTL and testbench

Parametrised pseudo-random delay timer for the reaction-test flow. It runs a free-running XNOR LFSR and draws a uniformly distributed delay in [MIN_DELAY, MIN_DELAY+RANGE-1] on request. It then counts that delay down on an external millisecond tick and pulses `expire` when the delay has elapsed. It sits between the test-sequencer FSM and the 1 ms tick generator, and replaces ad-hoc "LFSR + offset" logic.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_core.sv | 40 ++++
 rtl/lfsr_delay_gen.sv | 148 ++++++++++++++
 tb/tb_lfsr_delay_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR-based blocks.
package lfsr_pkg;

  // Delay generator control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDraw  = 2'd1,
    StCount = 2'd2
  } dly_state_e;

  // Maximal-length feedback masks for a left-shifting XNOR LFSR (bit i taps lfsr[i]).
  localparam logic [7:0]  Taps8  = 8'hB8;
  localparam logic [8:0]  Taps9  = 9'h110;
  localparam logic [9:0]  Taps10 = 10'h240;
  localparam logic [10:0] Taps11 = 11'h500;
  localparam logic [11:0] Taps12 = 12'h829;
  localparam logic [12:0] Taps13 = 13'h100D;
  localparam logic [13:0] Taps14 = 14'h2015;
  localparam logic [14:0] Taps15 = 15'h6000;
  localparam logic [15:0] Taps16 = 16'hD008;

  // All-ones value of the given width: the state an XNOR LFSR can never leave.
  function automatic logic [31:0] lockup_value(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running XNOR LFSR with seed load and lockup-state guard.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(Taps12)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] Lockup = WIDTH'(lockup_value(WIDTH));

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb;

  // Next state: seed load wins over the shift; an all-ones seed is mapped to 0.
  always_comb begin
    fb     = ~^(lfsr_q & TAPS);
    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    if (seed_load_i) begin
      lfsr_d = (seed_in_i == Lockup) ? '0 : seed_in_i;
    end
  end

  // Shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/lfsr_delay_gen.sv
// Pseudo-random delay timer: draws a delay from the LFSR by rejection sampling
// (with a fold fallback) and counts it down on an external tick.
module lfsr_delay_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 12,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(Taps12),
  parameter int unsigned      MIN_DELAY = 4000,
  parameter int unsigned      RANGE     = 4000,
  parameter int unsigned      MAX_TRIES = 4,
  parameter int unsigned      DELAY_W   = 13
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               seed_load_i,
  input  logic [WIDTH-1:0]   seed_in_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               tick_i,
  output logic               busy_o,
  output logic [DELAY_W-1:0] delay_val_o,
  output logic               delay_valid_o,
  output logic [DELAY_W-1:0] remaining_o,
  output logic               expire_o
);

  localparam int unsigned        TriesW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TriesW-1:0]  LastTry  = TriesW'(MAX_TRIES - 1);
  // One extra bit so RANGE = 2^WIDTH is representable.
  localparam logic [WIDTH:0]     RangeCmp = (WIDTH + 1)'(RANGE);
  localparam logic [DELAY_W-1:0] MinD     = DELAY_W'(MIN_DELAY);
  localparam logic [DELAY_W-1:0] RangeD   = DELAY_W'(RANGE);

  // Parameter sanity: the fold needs v - RANGE < RANGE, and no delay may wrap.
  if ((64'd1 << (WIDTH - 1)) > 64'(RANGE) || 64'(RANGE) > (64'd1 << WIDTH)) begin : g_bad_range
    $error("lfsr_delay_gen: RANGE must lie in [2^(WIDTH-1), 2^WIDTH]");
  end
  if (64'(MIN_DELAY) + 64'(RANGE) - 64'd1 >= (64'd1 << DELAY_W)) begin : g_bad_width
    $error("lfsr_delay_gen: MIN_DELAY+RANGE-1 does not fit in DELAY_W bits");
  end
  if (MIN_DELAY < 1) begin : g_bad_min
    $error("lfsr_delay_gen: MIN_DELAY must be at least 1");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_delay_gen: MAX_TRIES must be at least 1");
  end

  logic [WIDTH-1:0]   lfsr_q;
  dly_state_e         state_q, state_d;
  logic [TriesW-1:0]  tries_q, tries_d;
  logic [DELAY_W-1:0] remaining_q, remaining_d;
  logic [DELAY_W-1:0] delay_val_q, delay_val_d;
  logic               expire_q, expire_d;
  logic               in_range;
  logic               take;
  logic [DELAY_W-1:0] v_ext;
  logic [DELAY_W-1:0] drawn;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .seed_load_i (seed_load_i),
    .seed_in_i   (seed_in_i),
    .q_o         (lfsr_q)
  );

  // Candidate delay from the current LFSR value: direct if in range, folded otherwise.
  always_comb begin
    v_ext    = DELAY_W'(lfsr_q);
    in_range = ({1'b0, lfsr_q} < RangeCmp);
    drawn    = in_range ? (MinD + v_ext) : (MinD + (v_ext - RangeD));
  end

  // Next-state: draw, countdown and abort handling.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    remaining_d = remaining_q;
    delay_val_d = delay_val_q;
    expire_d    = 1'b0;
    take        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StDraw;
          tries_d = '0;
        end
      end
      StDraw: begin
        if (abort_i) begin
          state_d     = StIdle;
          remaining_d = '0;
        end else if (in_range || (tries_q == LastTry)) begin
          take        = 1'b1;
          delay_val_d = drawn;
          remaining_d = drawn;
          state_d     = StCount;
        end else begin
          tries_d = tries_q + TriesW'(1);
        end
      end
      StCount: begin
        if (abort_i) begin
          state_d     = StIdle;
          remaining_d = '0;
        end else if (tick_i) begin
          remaining_d = remaining_q - DELAY_W'(1);
          if (remaining_q == DELAY_W'(1)) begin
            expire_d = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        remaining_d = '0;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tries_q     <= '0;
      remaining_q <= '0;
      delay_val_q <= '0;
      expire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      remaining_q <= remaining_d;
      delay_val_q <= delay_val_d;
      expire_q    <= expire_d;
    end
  end

  // delay_valid marks the accepting DRAW cycle; delay_val shows the new value in that cycle.
  assign busy_o        = (state_q != StIdle);
  assign delay_valid_o = take;
  assign delay_val_o   = take ? drawn : delay_val_q;
  assign remaining_o   = remaining_q;
  assign expire_o      = expire_q;

endmodule

// File: tb/tb_lfsr_delay_gen.sv
// Self-checking bench for lfsr_delay_gen: reference model plus directed and random stimulus.
module tb_lfsr_delay_gen;

  localparam int W     = 12;
  localparam int DW    = 13;
  localparam int MIN   = 4000;
  localparam int RNG   = 4000;
  localparam int TRIES = 4;
  localparam int TAPSM = 'h829;
  localparam int MIdle = 0;
  localparam int MDraw = 1;
  localparam int MCnt  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tick = 1'b0;
  logic          busy;
  logic [DW-1:0] delay_val;
  logic          delay_valid;
  logic [DW-1:0] remaining;
  logic          expire;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_delay_gen dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seed_load_i   (seed_load),
    .seed_in_i     (seed_in),
    .start_i       (start),
    .abort_i       (abort),
    .tick_i        (tick),
    .busy_o        (busy),
    .delay_val_o   (delay_val),
    .delay_valid_o (delay_valid),
    .remaining_o   (remaining),
    .expire_o      (expire)
  );

  // Reference arithmetic straight from the rules.
  function automatic int lfsr_next(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) begin
      if (((TAPSM >> i) & 1) != 0) p ^= (v >> i) & 1;
    end
    return ((v << 1) & ((1 << W) - 1)) | (p ^ 1);
  endfunction

  function automatic int draw_of(input int v);
    return (v < RNG) ? (MIN + v) : (MIN + (v - RNG));
  endfunction

  // Model state.
  int m_lfsr  = 0;
  int m_mode  = MIdle;
  int m_tries = 0;
  int m_rem   = 0;
  int m_dval  = 0;
  int m_exp   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 0; m_mode <= MIdle; m_tries <= 0; m_rem <= 0; m_dval <= 0; m_exp <= 0;
    end else begin
      m_exp  <= 0;
      m_lfsr <= seed_load ? ((seed_in == 12'hFFF) ? 0 : int'(seed_in)) : lfsr_next(m_lfsr);
      if (m_mode == MIdle) begin
        if (start && !abort) begin
          m_mode  <= MDraw;
          m_tries <= 0;
        end
      end else if (abort) begin
        m_mode <= MIdle;
        m_rem  <= 0;
      end else if (m_mode == MDraw) begin
        if (m_lfsr < RNG || m_tries == TRIES - 1) begin
          m_dval <= draw_of(m_lfsr);
          m_rem  <= draw_of(m_lfsr);
          m_mode <= MCnt;
        end else begin
          m_tries <= m_tries + 1;
        end
      end else if (tick) begin
        if (m_rem == 1) begin
          m_exp  <= 1;
          m_mode <= MIdle;
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    automatic int e_valid = (m_mode == MDraw && !abort &&
                             (m_lfsr < RNG || m_tries == TRIES - 1)) ? 1 : 0;
    automatic int e_dval  = (e_valid != 0) ? draw_of(m_lfsr) : m_dval;
    automatic int e_busy  = (m_mode != MIdle) ? 1 : 0;
    n_cmp++;
    if (int'(busy) != e_busy || int'(delay_valid) != e_valid || int'(delay_val) != e_dval ||
        int'(remaining) != m_rem || int'(expire) != m_exp || int'(dut.lfsr_q) != m_lfsr) begin
      n_err++;
      $display("FAIL cycle@%0t: got busy=%0d vld=%0d val=%0d rem=%0d exp=%0d lfsr=%0h, expected %0d %0d %0d %0d %0d %0h",
               $time, busy, delay_valid, delay_val, remaining, expire, dut.lfsr_q,
               e_busy, e_valid, e_dval, m_rem, m_exp, m_lfsr);
    end
    if (delay_valid && expire) begin
      n_err++;
      $display("FAIL valid_expire_overlap@%0t: got both high, expected never together", $time);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rem(input int target, input string name);
    int n = 0;
    while (int'(remaining) != target && n < 6000) begin
      step();
      n++;
    end
    check(name, int'(remaining), target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_delay_val"}, int'(delay_val), 0);
    check({tag, "_delay_valid"}, int'(delay_valid), 0);
    check({tag, "_remaining"}, int'(remaining), 0);
    check({tag, "_expire"}, int'(expire), 0);
  endtask

  initial begin
    int n;
    int bad;
    int prev;
    int pat;
    int seen;
    int first_zero;

    // Reset state and the first LFSR steps from 0.
    #2 rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    check("lfsr_after_reset", int'(dut.lfsr_q), 0);
    step(); check("lfsr_step1", int'(dut.lfsr_q), 'h001);
    step(); check("lfsr_step2", int'(dut.lfsr_q), 'h002);
    step(); check("lfsr_step3", int'(dut.lfsr_q), 'h005);

    // Seed accepted on the first try; tick held high through the accepting cycle.
    seed_in = 12'h123; seed_load = 1'b1; start = 1'b1;
    step();
    seed_load = 1'b0; start = 1'b0;
    check("seed_valid", int'(delay_valid), 1);
    check("seed_delay_val", int'(delay_val), 4291);
    tick = 1'b1;
    step();
    check("first_tick_not_counted", int'(remaining), 4291);
    n = 0; bad = 0; prev = 4291;
    while (!expire && n < 5000) begin
      start = ((n % 997) == 0);
      step();
      n++;
      if (int'(remaining) != prev - 1) bad++;
      prev = int'(remaining);
    end
    start = 1'b0;
    check("ticks_to_expire", n, 4291);
    check("remaining_monotonic", bad, 0);
    check("busy_drop_at_expire", int'(busy), 0);
    step();
    check("expire_single_pulse", int'(expire), 0);
    check("start_while_busy_ignored", int'(busy), 0);

    // Four rejected candidates 0xFFE,0xFFC,0xFF8,0xFF0: fold on the last gives 4080.
    tick = 1'b0;
    seed_in = 12'hFFE; seed_load = 1'b1; start = 1'b1;
    step();
    seed_load = 1'b0; start = 1'b0;
    pat = 0;
    for (int k = 0; k < 4; k++) begin
      if (delay_valid) pat |= (1 << k);
      if (k == 3) check("fold_delay_val", int'(delay_val), 4080);
      if (k < 3) step();
    end
    check("fold_latency_pattern", pat, 'b1000);

    // Abort near the end of the countdown.
    tick = 1'b1;
    step();
    wait_rem(3, "reach_rem3");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_remaining", int'(remaining), 0);
    check("abort_delay_val_kept", int'(delay_val), 4080);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (expire) seen++;
      step();
    end
    check("abort_no_expire", seen, 0);

    // start together with abort in IDLE: no draw.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", int'(busy), 0);
    step();
    check("start_abort_idle_next", int'(busy), 0);

    // Asynchronous reset in the middle of a countdown.
    seed_in = 12'h010; seed_load = 1'b1; start = 1'b1;
    step();
    seed_load = 1'b0; start = 1'b0;
    check("seed10_delay_val", int'(delay_val), 4016);
    step();
    wait_rem(50, "reach_rem50");
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("lfsr_after_async_reset", int'(dut.lfsr_q), 0);
    step();
    check("no_resume_busy", int'(busy), 0);
    check("lfsr_resume_step1", int'(dut.lfsr_q), 1);

    // Lockup seed and full period.
    seed_in = 12'hFFF; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("lockup_seed_mapped", int'(dut.lfsr_q), 0);
    seen = 0; first_zero = -1;
    for (int i = 1; i <= 4095; i++) begin
      step();
      if (dut.lfsr_q == 12'hFFF) seen++;
      if (dut.lfsr_q == 12'h000 && first_zero < 0) first_zero = i;
    end
    check("lockup_never_seen", seen, 0);
    check("period_4095", first_zero, 4095);

    // Randomised operation against the model.
    for (int i = 0; i < 40000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      abort     = ($urandom_range(0, 19999) == 0);
      tick      = ($urandom_range(0, 9) != 0);
      seed_load = ($urandom_range(0, 199) == 0);
      seed_in   = ($urandom_range(0, 7) == 0) ? 12'hFFF : W'($urandom_range(0, 4095));
      step();
    end
    start = 1'b0; abort = 1'b0; tick = 1'b0; seed_load = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
